// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth digit recoder for the sequential multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } booth_state_t;

    typedef enum logic [2:0] {
        SEL_ZERO,
        SEL_POS1,
        SEL_POS2,
        SEL_NEG1,
        SEL_NEG2
    } booth_sel_t;

    // Map a multiplier bit triplet (b[2i+1], b[2i], b[2i-1]) to a digit in {-2..+2}.
    function automatic booth_sel_t booth_recode(input logic [2:0] bits);
        booth_sel_t sel;
        case (bits)
            3'b000, 3'b111: sel = SEL_ZERO;
            3'b001, 3'b010: sel = SEL_POS1;
            3'b011:         sel = SEL_POS2;
            3'b100:         sel = SEL_NEG2;
            default:        sel = SEL_NEG1;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// Combinational partial-product generator for one radix-4 Booth digit.
// Negative digits come out as one's complement; neg is the +1 carry-in
// that completes the two's-complement negation in the accumulator add.
module booth_r4_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH+1:0] a_ext,
    input  booth_sel_t       sel,
    output logic [WIDTH+2:0] pp,
    output logic             neg
);

    logic [WIDTH+2:0] a_one;
    logic [WIDTH+2:0] a_two;

    // 1A is sign-extended by one bit; 2A is a left shift that fits the same width.
    assign a_one = {a_ext[WIDTH+1], a_ext};
    assign a_two = {a_ext, 1'b0};

    // Select the digit multiple and apply one's complement for negative digits.
    always_comb begin
        pp  = '0;
        neg = 1'b0;
        case (sel)
            SEL_POS1: pp = a_one;
            SEL_POS2: pp = a_two;
            SEL_NEG1: begin
                pp  = ~a_one;
                neg = 1'b1;
            end
            SEL_NEG2: begin
                pp  = ~a_two;
                neg = 1'b1;
            end
            default: begin
                pp  = '0;
                neg = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_r4_mult_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit retired per BUSY cycle
// into a wide accumulator, valid/ready handshakes on both sides.
module booth_r4_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int NDIG  = WIDTH / 2 + 1;
    localparam int EXT_W = WIDTH + 2;
    localparam int PP_W  = WIDTH + 3;
    localparam int ACC_W = 2 * WIDTH + 4;
    localparam int CNT_W = $clog2(NDIG);
    localparam int SH_W  = CNT_W + 1;

    generate
        if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("booth_r4_mult_seq: WIDTH must be even and >= 4");
        end
    endgenerate

    booth_state_t        state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [EXT_W-1:0]    a_reg;
    // Multiplier with the implicit b[-1]=0 in bit 0; shifted right by two each digit.
    logic [EXT_W:0]      b_reg;
    logic [ACC_W-1:0]    acc_reg;
    logic                in_ready_reg;
    logic                out_valid_reg;
    logic [2*WIDTH-1:0]  out_p_reg;
    logic                busy_reg;

    booth_sel_t          sel;
    logic [PP_W-1:0]     pp;
    logic                neg;
    logic [ACC_W-1:0]    pp_ext;
    logic [ACC_W-1:0]    addend;
    logic [ACC_W-1:0]    acc_next;
    logic [SH_W-1:0]     shamt;
    logic [EXT_W-1:0]    a_in_ext;
    logic [EXT_W-1:0]    b_in_ext;

    assign sel = booth_recode(b_reg[2:0]);

    booth_r4_pp_gen #(
        .WIDTH(WIDTH)
    ) u_pp_gen (
        .a_ext(a_reg),
        .sel  (sel),
        .pp   (pp),
        .neg  (neg)
    );

    // Weight the signed partial product (plus its negate carry) by 4^digit.
    always_comb begin
        shamt    = {cnt_reg, 1'b0};
        pp_ext   = {{(ACC_W-PP_W){pp[PP_W-1]}}, pp};
        addend   = (pp_ext + {{(ACC_W-1){1'b0}}, neg}) << shamt;
        acc_next = acc_reg + addend;
    end

    // Operand extension on accept: sign or zero per transaction mode.
    always_comb begin
        a_in_ext = in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
        b_in_ext = in_signed ? {{2{in_b[WIDTH-1]}}, in_b} : {2'b00, in_b};
    end

    // Control FSM, digit counter, accumulator and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            acc_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_p_reg     <= '0;
            busy_reg      <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= a_in_ext;
                        b_reg        <= {b_in_ext, 1'b0};
                        acc_reg      <= '0;
                        cnt_reg      <= '0;
                        state_reg    <= BUSY;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                BUSY: begin
                    acc_reg <= acc_next;
                    b_reg   <= {2'b00, b_reg[EXT_W:2]};
                    if (cnt_reg == CNT_W'(NDIG - 1)) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        out_p_reg     <= acc_next[2*WIDTH-1:0];
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_p     = out_p_reg;
    assign busy      = busy_reg;

endmodule
